// File: rtl/mc_controller.sv
// Multicycle control FSM for the ARM-subset datapath with UMULL/SMULL support.
// Moore outputs come from the state register and the latched instruction only.
module mc_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic        RegWriteHi,
  output logic        MemWrite,
  output logic        AdrSrc,
  output logic        ALUSrcA,
  output logic [1:0]  RegSrc,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ImmSrc,
  output logic [2:0]  ALUControl,
  output logic [3:0]  State
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,  DECODE   = 4'd1,  MEMADR = 4'd2,  MEMRD = 4'd3,
    MEMWB    = 4'd4,  MEMWR    = 4'd5,  EXECUTER = 4'd6, EXECUTEI = 4'd7,
    ALUWB    = 4'd8,  BRANCH   = 4'd9,  MULEX  = 4'd10, MULWB = 4'd11
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  flags_q, flags_d;

  logic [1:0]  op;
  logic [3:0]  cond, cmd, rd;
  logic        s_bit, is_mul, is_long, is_signed, is_cmp, dp_valid, is_nop;
  logic        cond_ex, n_f, z_f, c_f, v_f;
  logic [2:0]  dp_alu;
  logic        pcw, irw, rw, rwh, mw;

  assign op        = Instr[27:26];
  assign cond      = Instr[31:28];
  assign cmd       = Instr[24:21];
  assign rd        = Instr[15:12];
  assign s_bit     = Instr[20];
  assign is_mul    = (Instr[27:24] == 4'b0000) && (Instr[7:4] == 4'b1001);
  assign is_long   = Instr[23];
  assign is_signed = Instr[22];
  assign is_cmp    = (cmd == 4'b1010);
  assign dp_valid  = (cmd == 4'b0000) || (cmd == 4'b0010) || (cmd == 4'b0100) ||
                     (cmd == 4'b1100) || is_cmp;
  assign is_nop    = (op == 2'b11) || ((op == 2'b00) && !is_mul && !dp_valid);

  // Register fields are consumed by the datapath, not here.
  logic unused_instr;
  assign unused_instr = ^{Instr[19:16], Instr[11:8], Instr[3:0]};

  assign {n_f, z_f, c_f, v_f} = flags_q;

  always_comb begin
    case (cond)
      4'b0000: cond_ex = z_f;
      4'b0001: cond_ex = !z_f;
      4'b0010: cond_ex = c_f;
      4'b0011: cond_ex = !c_f;
      4'b0100: cond_ex = n_f;
      4'b0101: cond_ex = !n_f;
      4'b0110: cond_ex = v_f;
      4'b0111: cond_ex = !v_f;
      4'b1000: cond_ex = c_f && !z_f;
      4'b1001: cond_ex = !c_f || z_f;
      4'b1010: cond_ex = (n_f == v_f);
      4'b1011: cond_ex = (n_f != v_f);
      4'b1100: cond_ex = !z_f && (n_f == v_f);
      4'b1101: cond_ex = z_f || (n_f != v_f);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  always_comb begin
    case (cmd)
      4'b0000:          dp_alu = 3'b010;
      4'b0010, 4'b1010: dp_alu = 3'b001;
      4'b1100:          dp_alu = 3'b011;
      default:          dp_alu = 3'b000;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FETCH;
      flags_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
    end
  end

  always_comb begin
    state_d    = FETCH;
    flags_d    = flags_q;
    pcw        = 1'b0;
    irw        = 1'b0;
    rw         = 1'b0;
    rwh        = 1'b0;
    mw         = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ALUControl = 3'b000;
    case (state_q)
      FETCH: begin
        irw = 1'b1; pcw = 1'b1;
        ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
        state_d = DECODE;
      end
      DECODE: begin
        // PC+4 already latched, so the ALU path here presents R15 as PC+8.
        ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
        if (!cond_ex || is_nop) state_d = FETCH;
        else if (is_mul)        state_d = MULEX;
        else if (op == 2'b01)   state_d = MEMADR;
        else if (op == 2'b10)   state_d = BRANCH;
        else if (Instr[25])     state_d = EXECUTEI;
        else                    state_d = EXECUTER;
      end
      MEMADR: begin
        ALUSrcB = 2'b01;
        ALUControl = Instr[23] ? 3'b000 : 3'b001;
        state_d = s_bit ? MEMRD : MEMWR;
      end
      MEMRD: begin
        AdrSrc = 1'b1;
        state_d = MEMWB;
      end
      MEMWB: begin
        ResultSrc = 2'b01; rw = 1'b1;
        pcw = (rd == 4'd15);
      end
      MEMWR: begin
        AdrSrc = 1'b1; mw = 1'b1;
      end
      EXECUTER, EXECUTEI: begin
        ALUSrcB = (state_q == EXECUTEI) ? 2'b01 : 2'b00;
        ALUControl = dp_alu;
        if (s_bit || is_cmp) flags_d = ALUFlags;
        state_d = ALUWB;
      end
      ALUWB: begin
        rw  = !is_cmp;
        pcw = !is_cmp && (rd == 4'd15);
      end
      BRANCH: begin
        ALUSrcB = 2'b01; ResultSrc = 2'b10; pcw = 1'b1;
      end
      MULEX: begin
        ALUControl = !is_long ? 3'b100 : (is_signed ? 3'b110 : 3'b101);
        // Multiplies leave C and V alone.
        if (s_bit) flags_d[3:2] = ALUFlags[3:2];
        state_d = MULWB;
      end
      MULWB: begin
        rw = 1'b1; rwh = is_long;
      end
      default: state_d = FETCH;
    endcase
  end

  assign PCWrite    = pcw & reset;
  assign IRWrite    = irw & reset;
  assign RegWrite   = rw  & reset;
  assign RegWriteHi = rwh & reset;
  assign MemWrite   = mw  & reset;

  assign ImmSrc    = (op == 2'b11) ? 2'b00 : op;
  assign RegSrc[0] = (op == 2'b10);
  assign RegSrc[1] = (op == 2'b01) && !s_bit;
  assign State     = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: per-cycle expectations queued per instruction.
module tb_mc_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite, IRWrite, RegWrite, RegWriteHi, MemWrite, AdrSrc, ALUSrcA;
  logic [1:0]  RegSrc, ALUSrcB, ResultSrc, ImmSrc;
  logic [2:0]  ALUControl;
  logic [3:0]  State;

  mc_controller dut (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .RegWriteHi(RegWriteHi), .MemWrite(MemWrite), .AdrSrc(AdrSrc),
    .ALUSrcA(ALUSrcA), .RegSrc(RegSrc), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl), .State(State)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] st;
    logic [4:0] we;   // {PCWrite,IRWrite,RegWrite,RegWriteHi,MemWrite}
    logic [2:0] alu;
    logic [5:0] sel;  // {AdrSrc,ALUSrcA,ALUSrcB,ResultSrc}
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  logic [4:0] we_o;
  logic [5:0] sel_o;
  assign we_o  = {PCWrite, IRWrite, RegWrite, RegWriteHi, MemWrite};
  assign sel_o = {AdrSrc, ALUSrcA, ALUSrcB, ResultSrc};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic push(input logic [3:0] st, input logic [4:0] we,
                      input logic [2:0] alu, input logic [5:0] sel);
    exp_t e;
    e.st = st; e.we = we; e.alu = alu; e.sel = sel;
    sb.push_back(e);
  endtask

  task automatic p_fd();
    push(4'd0, 5'b11000, 3'b000, 6'b011010);
    push(4'd1, 5'b00000, 3'b000, 6'b011010);
  endtask

  // Pops the queue one cycle at a time; entered and left at a falling edge.
  task automatic run(input logic [31:0] ins, input logic [3:0] fl,
                     input logic [3:0] stat, input bit cs);
    exp_t e;
    Instr = ins; ALUFlags = fl;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      #1;
      chk("state", State, e.st);
      chk("we", we_o, e.we);
      chk("aluctl", ALUControl, e.alu);
      chk("sel", sel_o, e.sel);
      if (cs) chk("static", {ImmSrc, RegSrc}, stat);
      @(posedge clk); @(negedge clk);
    end
  endtask

  task automatic rst_chk(input string tag);
    chk({tag, "_st"}, State, 0);
    chk({tag, "_we"}, we_o, 0);
    chk({tag, "_sel"}, sel_o, 6'b011010);
  endtask

  initial begin
    reset = 1'b0; Instr = 32'hE0832291; ALUFlags = 4'hF;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      #1 rst_chk("rst");
      @(negedge clk);
    end
    reset = 1'b1;

    // ADDS R1,R2,#5 ; ALU reports Z
    p_fd(); push(7, 0, 3'b000, 6'b000100); push(8, 5'b00100, 3'b000, 0);
    run(32'hE2921005, 4'b0100, 4'b0000, 1);
    // SUBNE skipped, ADDEQ (no S) executes: Z held
    p_fd(); run(32'h10421003, 4'b0000, 4'b0000, 1);
    p_fd(); push(6, 0, 3'b000, 0); push(8, 5'b00100, 3'b000, 0);
    run(32'h00821003, 4'b1111, 4'b0000, 1);
    // LDR, STR, LDR PC with negative offset
    p_fd(); push(2, 0, 3'b000, 6'b000100); push(3, 0, 3'b000, 6'b100000);
    push(4, 5'b00100, 3'b000, 6'b000001);
    run(32'hE5912004, 4'b0000, 4'b0100, 1);
    p_fd(); push(2, 0, 3'b000, 6'b000100); push(5, 5'b00001, 3'b000, 6'b100000);
    run(32'hE5812004, 4'b0000, 4'b0110, 1);
    p_fd(); push(2, 0, 3'b001, 6'b000100); push(3, 0, 3'b000, 6'b100000);
    push(4, 5'b10100, 3'b000, 6'b000001);
    run(32'hE511F004, 4'b0000, 4'b0100, 1);
    // AND, ORR, ADD to PC, MOV (NOP), Op=11 (NOP)
    p_fd(); push(6, 0, 3'b010, 0); push(8, 5'b00100, 3'b000, 0);
    run(32'hE0021003, 4'b0000, 4'b0000, 1);
    p_fd(); push(6, 0, 3'b011, 0); push(8, 5'b00100, 3'b000, 0);
    run(32'hE1821003, 4'b0000, 4'b0000, 1);
    p_fd(); push(6, 0, 3'b000, 0); push(8, 5'b10100, 3'b000, 0);
    run(32'hE082F003, 4'b0000, 4'b0000, 1);
    p_fd(); run(32'hE1A01002, 4'b0000, 4'b0000, 1);
    p_fd(); run(32'hEC000000, 4'b0000, 4'b0000, 0);
    // CMP R1,#0 -> flags C only; BEQ skipped
    p_fd(); push(7, 0, 3'b001, 6'b000100); push(8, 0, 3'b000, 0);
    run(32'hE3510000, 4'b0010, 4'b0000, 1);
    p_fd(); run(32'h0AFFFFFE, 4'b0000, 4'b1001, 1);
    // MULS loads N,Z only (ALU V=1, C=0 must be ignored)
    p_fd(); push(10, 0, 3'b100, 0); push(11, 5'b00100, 3'b000, 0);
    run(32'hE0130291, 4'b1101, 4'b0000, 1);
    p_fd(); push(9, 5'b10000, 3'b000, 6'b000110);
    run(32'h2AFFFFFE, 4'b0000, 4'b1001, 1);
    p_fd(); push(9, 5'b10000, 3'b000, 6'b000110);
    run(32'h4AFFFFFE, 4'b0000, 4'b1001, 1);
    p_fd(); run(32'h6AFFFFFE, 4'b0000, 4'b1001, 1);
    // UMULL, SMULL, MUL
    p_fd(); push(10, 0, 3'b101, 0); push(11, 5'b00110, 3'b000, 0);
    run(32'hE0832291, 4'b1111, 4'b0000, 1);
    p_fd(); push(10, 0, 3'b110, 0); push(11, 5'b00110, 3'b000, 0);
    run(32'hE0C32291, 4'b1111, 4'b0000, 1);
    p_fd(); push(10, 0, 3'b100, 0); push(11, 5'b00100, 3'b000, 0);
    run(32'hE0030291, 4'b1111, 4'b0000, 1);
    // B always
    p_fd(); push(9, 5'b10000, 3'b000, 6'b000110);
    run(32'hEAFFFFFE, 4'b0000, 4'b1001, 1);

    // Reset mid-UMULL while flags hold N,Z,C set
    p_fd(); run(32'hE0832291, 4'b0000, 4'b0000, 1);
    #1 chk("mid_st", State, 10);
    reset = 1'b0;
    #1 rst_chk("mid_rst");
    @(posedge clk); @(negedge clk);
    #1 rst_chk("mid_hold");
    reset = 1'b1;
    // Flags cleared: BEQ skipped, BCC taken
    p_fd(); run(32'h0AFFFFFE, 4'b0000, 4'b1001, 1);
    p_fd(); push(9, 5'b10000, 3'b000, 6'b000110);
    run(32'h3AFFFFFE, 4'b0000, 4'b1001, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got %0d exp %0d", 1, 0);
    $fatal(1, "timeout");
  end

endmodule
